// File: rtl/tank_level_emulator.sv
// Tank level emulator: integrates a water-level counter from the actuator
// commands (Ve inlet, Bs sprinkler pump, Vs drip valve) once per prescaled
// tick and publishes registered threshold sensors H/M/L, with optional
// sensor fault injection for exercising the controller's error path.
//
// Interface timing:
//   - tick is high for the single cycle in which the prescaler sits on its
//     last count while run=1; the integration step is taken on that edge and
//     the new level is visible the following cycle.
//   - load_en is a one-cycle pulse sampled on the rising edge; it overrides
//     an integration step landing on the same edge.
//   - H/M/L follow the level register with one cycle of latency.
module tank_level_emulator #(
  parameter int LEVEL_W    = 8,
  parameter int MAX_LEVEL  = 200,
  parameter int L_TH       = 40,
  parameter int M_TH       = 100,
  parameter int H_TH       = 160,
  parameter int TICK_DIV   = 50000000,
  parameter int FILL_RATE  = 5,
  parameter int ASP_RATE   = 3,
  parameter int GOT_RATE   = 1,
  parameter int INIT_LEVEL = 120
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               run,
  input  logic               Ve,
  input  logic               Bs,
  input  logic               Vs,
  input  logic               load_en,
  input  logic [LEVEL_W-1:0] load_val,
  input  logic [1:0]         fault_sel,
  output logic               H,
  output logic               M,
  output logic               L,
  output logic [LEVEL_W-1:0] level,
  output logic               tick,
  output logic [1:0]         dir,
  output logic               overflow,
  output logic               dry
);

  // Prescaler sizing; a divide-by-one still needs a one-bit counter.
  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  // Two spare bits: one for headroom above MAX_LEVEL, one for the sign.
  localparam int SUM_W = LEVEL_W + 2;

  localparam logic [LEVEL_W-1:0]      MAX_U  = LEVEL_W'(MAX_LEVEL);
  localparam logic [LEVEL_W-1:0]      INIT_U = LEVEL_W'(INIT_LEVEL);
  localparam logic signed [SUM_W-1:0] MAX_S  = SUM_W'(MAX_LEVEL);
  localparam logic signed [SUM_W-1:0] FILL_S = SUM_W'(FILL_RATE);
  localparam logic signed [SUM_W-1:0] ASP_S  = SUM_W'(ASP_RATE);
  localparam logic signed [SUM_W-1:0] GOT_S  = SUM_W'(GOT_RATE);

  localparam logic [LEVEL_W-1:0] L_TH_U = LEVEL_W'(L_TH);
  localparam logic [LEVEL_W-1:0] M_TH_U = LEVEL_W'(M_TH);
  localparam logic [LEVEL_W-1:0] H_TH_U = LEVEL_W'(H_TH);

  // Fault-free sensor readings for the reset level.
  localparam logic INIT_H = (INIT_LEVEL >= H_TH);
  localparam logic INIT_M = (INIT_LEVEL >= M_TH);
  localparam logic INIT_L = (INIT_LEVEL >= L_TH);

  typedef enum logic [1:0] {
    DIR_HOLD = 2'b00,
    DIR_RISE = 2'b01,
    DIR_FALL = 2'b10
  } dir_t;

  typedef enum logic [1:0] {
    FAULT_NONE  = 2'b00,
    FAULT_L_LOW = 2'b01,
    FAULT_M_LOW = 2'b10,
    FAULT_ALL   = 2'b11
  } fault_t;

  logic [CNT_W-1:0]         cnt;
  logic [LEVEL_W-1:0]       level_q;
  dir_t                     dir_q;
  logic                     overflow_q;
  logic                     dry_q;

  logic signed [SUM_W-1:0]  level_s;
  logic signed [SUM_W-1:0]  inflow;
  logic signed [SUM_W-1:0]  outflow;
  logic signed [SUM_W-1:0]  next_raw;
  logic                     clip_hi;
  logic                     clip_lo;
  logic [LEVEL_W-1:0]       next_level;
  dir_t                     next_dir;
  logic [LEVEL_W-1:0]       load_clamped;

  logic                     raw_h;
  logic                     raw_m;
  logic                     raw_l;
  fault_t                   fault;

  assign level    = level_q;
  assign dir      = dir_q;
  assign overflow = overflow_q;
  assign dry      = dry_q;
  assign fault    = fault_t'(fault_sel);

  // Tick marks the last prescaler count; frozen prescaler never ticks.
  assign tick = run && (cnt == CNT_LAST);

  // Prescaler: free-running modulo TICK_DIV counter gated by run.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= '0;
    end else if (run) begin
      if (cnt == CNT_LAST) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Next level from the flow balance, clipped to the physical tank range.
  always_comb begin
    level_s  = $signed({2'b00, level_q});
    inflow   = Ve ? FILL_S : '0;
    outflow  = (Bs ? ASP_S : '0) + (Vs ? GOT_S : '0);
    next_raw = level_s + inflow - outflow;
    clip_hi  = (next_raw > MAX_S);
    clip_lo  = next_raw[SUM_W-1];
    if (clip_hi) begin
      next_level = MAX_U;
    end else if (clip_lo) begin
      next_level = '0;
    end else begin
      next_level = next_raw[LEVEL_W-1:0];
    end
    // Trend is judged on the clipped value, so a tank already pinned at a
    // bound that keeps being pushed past it reports HOLD.
    if (next_level > level_q) begin
      next_dir = DIR_RISE;
    end else if (next_level < level_q) begin
      next_dir = DIR_FALL;
    end else begin
      next_dir = DIR_HOLD;
    end
  end

  // Loaded values beyond the full tank are pinned to the ceiling.
  always_comb begin
    load_clamped = (load_val > MAX_U) ? MAX_U : load_val;
  end

  // Level, trend and sticky clip flags; load overrides a coincident tick.
  always_ff @(posedge clock) begin
    if (reset) begin
      level_q    <= INIT_U;
      dir_q      <= DIR_HOLD;
      overflow_q <= 1'b0;
      dry_q      <= 1'b0;
    end else if (load_en) begin
      level_q <= load_clamped;
      dir_q   <= DIR_HOLD;
    end else if (tick) begin
      level_q <= next_level;
      dir_q   <= next_dir;
      if (clip_hi) begin
        overflow_q <= 1'b1;
      end
      if (clip_lo) begin
        dry_q <= 1'b1;
      end
    end
  end

  // Raw threshold comparisons against the current level register.
  always_comb begin
    raw_h = (level_q >= H_TH_U);
    raw_m = (level_q >= M_TH_U);
    raw_l = (level_q >= L_TH_U);
  end

  // Registered sensors with fault masking applied on the way out.
  always_ff @(posedge clock) begin
    if (reset) begin
      H <= INIT_H;
      M <= INIT_M;
      L <= INIT_L;
    end else begin
      case (fault)
        FAULT_L_LOW: begin
          H <= raw_h;
          M <= raw_m;
          L <= 1'b0;
        end
        FAULT_M_LOW: begin
          H <= raw_h;
          M <= 1'b0;
          L <= raw_l;
        end
        FAULT_ALL: begin
          H <= 1'b0;
          M <= 1'b0;
          L <= 1'b0;
        end
        default: begin
          H <= raw_h;
          M <= raw_m;
          L <= raw_l;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tank_level_emulator.sv
// Bench for tank_level_emulator with TICK_DIV=4: directed scenarios plus a
// randomized phase, all checked every cycle against a behavioural tank model.
module tb_tank_level_emulator;

  localparam int TDIV = 4;

  // ---------------- clock / reset / DUT ----------------
  logic       clock = 1'b0;
  logic       reset;
  logic       run;
  logic       Ve;
  logic       Bs;
  logic       Vs;
  logic       load_en;
  logic [7:0] load_val;
  logic [1:0] fault_sel;
  logic       H;
  logic       M;
  logic       L;
  logic [7:0] level;
  logic       tick;
  logic [1:0] dir;
  logic       overflow;
  logic       dry;

  always #5 clock = ~clock;

  tank_level_emulator #(.TICK_DIV(TDIV)) dut (
    .clock(clock), .reset(reset), .run(run), .Ve(Ve), .Bs(Bs), .Vs(Vs),
    .load_en(load_en), .load_val(load_val), .fault_sel(fault_sel),
    .H(H), .M(M), .L(L), .level(level), .tick(tick), .dir(dir),
    .overflow(overflow), .dry(dry)
  );

  // ---------------- scoreboard counters ----------------
  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // ---------------- behavioural tank model ----------------
  // Plain integer tank: cycle counter mod TDIV, level in integer units.
  bit m_valid = 1'b0;
  int m_cnt;
  int m_level;
  int m_dir;
  bit m_ovf;
  bit m_dry;
  bit m_H;
  bit m_M;
  bit m_L;
  int m_next;
  bit m_tick;

  always @(posedge clock) begin
    if (reset) begin
      m_cnt   = 0;
      m_level = 120;
      m_dir   = 0;
      m_ovf   = 1'b0;
      m_dry   = 1'b0;
      m_H     = 1'b0;
      m_M     = 1'b1;
      m_L     = 1'b1;
      m_valid = 1'b1;
    end else if (m_valid) begin
      m_H = (m_level >= 160) && (fault_sel != 2'd3);
      m_M = (m_level >= 100) && (fault_sel != 2'd2) && (fault_sel != 2'd3);
      m_L = (m_level >= 40)  && (fault_sel != 2'd1) && (fault_sel != 2'd3);
      m_tick = run && (m_cnt == TDIV - 1);
      if (run) m_cnt = (m_cnt + 1) % TDIV;
      if (load_en) begin
        m_level = (load_val > 200) ? 200 : int'(load_val);
        m_dir   = 0;
      end else if (m_tick) begin
        m_next = m_level + (Ve ? 5 : 0) - (Bs ? 3 : 0) - (Vs ? 1 : 0);
        if (m_next > 200) begin
          m_ovf  = 1'b1;
          m_next = 200;
        end else if (m_next < 0) begin
          m_dry  = 1'b1;
          m_next = 0;
        end
        m_dir   = (m_next > m_level) ? 1 : ((m_next < m_level) ? 2 : 0);
        m_level = m_next;
      end
    end
  end

  // Compare process: every cycle on the falling edge once the model is live.
  initial begin
    forever begin
      @(negedge clock);
      if (m_valid) begin
        check("level",    32'(level),    32'(m_level));
        check("tick",     32'(tick),     32'(run && (m_cnt == TDIV - 1)));
        check("dir",      32'(dir),      32'(m_dir));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("dry",      32'(dry),      32'(m_dry));
        check("H",        32'(H),        32'(m_H));
        check("M",        32'(M),        32'(m_M));
        check("L",        32'(L),        32'(m_L));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic load(input int v);
    load_en  = 1'b1;
    load_val = 8'(v);
    step(1);
    load_en  = 1'b0;
  endtask

  // Advance until the current cycle is a tick cycle (run must be 1).
  task automatic wait_tick();
    int guard = 0;
    while (!(m_cnt == TDIV - 1) && guard < 2 * TDIV) begin
      step(1);
      guard++;
    end
    check("wait_tick_bound", 32'(guard < 2 * TDIV), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; run = 1'b0; Ve = 1'b0; Bs = 1'b0; Vs = 1'b0;
    load_en = 1'b0; load_val = '0; fault_sel = 2'b00;
    step(2);
    reset = 1'b0;

    // Reset state pinned with literals.
    check("lit_reset_level", 32'(level), 32'd120);
    check("lit_reset_L",     32'(L),     32'd1);
    check("lit_reset_M",     32'(M),     32'd1);
    check("lit_reset_H",     32'(H),     32'd0);
    check("lit_reset_flags", 32'({overflow, dry}), 32'd0);

    // Idle tank: ticks but no movement.
    run = 1'b1;
    step(12);
    check("lit_idle_level", 32'(level), 32'd120);
    check("lit_idle_dir",   32'(dir),   32'd0);

    // Filling: 8 ticks to 160, 8 more to 200 exactly, then a clipping tick.
    Ve = 1'b1;
    step(32);
    check("lit_fill8_level", 32'(level), 32'd160);
    step(32);
    check("lit_fill16_level", 32'(level),    32'd200);
    check("lit_fill16_ovf",   32'(overflow), 32'd0);
    step(TDIV);
    check("lit_clip_ovf", 32'(overflow), 32'd1);
    check("lit_clip_dir", 32'(dir),      32'd0);

    // Draining: from 5 the second tick clips; from 4 the tick lands on 0.
    Ve = 1'b0; Bs = 1'b1; Vs = 1'b1;
    load(5);
    step(TDIV);
    check("lit_drain5_t1_level", 32'(level), 32'd1);
    check("lit_drain5_t1_dry",   32'(dry),   32'd0);
    step(TDIV);
    check("lit_drain5_t2_level", 32'(level), 32'd0);
    check("lit_drain5_t2_dry",   32'(dry),   32'd1);
    load(4);
    step(TDIV);
    check("lit_drain4_level", 32'(level), 32'd0);

    // Fault injection on L and M, then all sensors.
    Bs = 1'b0; Vs = 1'b0;
    load(110);
    fault_sel = 2'b01;
    step(1);
    check("lit_fault01", 32'({H, M, L}), 32'b010);
    fault_sel = 2'b00;
    step(1);
    check("lit_fault00", 32'({H, M, L}), 32'b011);
    load(170);
    fault_sel = 2'b10;
    step(1);
    check("lit_fault10", 32'({H, M, L}), 32'b101);
    fault_sel = 2'b11;
    step(1);
    check("lit_fault11", 32'({H, M, L}), 32'b000);
    fault_sel = 2'b00;
    load(250);
    check("lit_load_clamp", 32'(level), 32'd200);

    // Frozen prescaler with inlet open: no movement.
    load(100);
    Ve = 1'b1; run = 1'b0;
    step(10);
    check("lit_frozen_level", 32'(level), 32'd100);

    // Reset landing on a tick cycle.
    run = 1'b1;
    wait_tick();
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check("lit_midtick_level", 32'(level), 32'd120);
    check("lit_midtick_flags", 32'({overflow, dry}), 32'd0);

    // Load coinciding with a tick wins.
    wait_tick();
    load(50);
    check("lit_load_on_tick", 32'(level), 32'd50);
    check("lit_load_on_tick_dir", 32'(dir), 32'd0);

    // Randomized phase.
    for (int i = 0; i < 1500; i++) begin
      run       = ($urandom_range(0, 9) != 0);
      Ve        = 1'($urandom_range(0, 1));
      Bs        = 1'($urandom_range(0, 1));
      Vs        = 1'($urandom_range(0, 1));
      fault_sel = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      load_en   = ($urandom_range(0, 24) == 0);
      load_val  = 8'($urandom_range(0, 255));
      reset     = ($urandom_range(0, 299) == 0);
      step(1);
    end
    reset = 1'b0; load_en = 1'b0;
    step(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
